// File: rtl/bbq_deque_collector.sv
// Return-path collector for the BBQ two-heap scheduler: buffers each heap's
// dequeue-max responses and replays them as one stream in original issue order.
package bbq_pkg;
  typedef enum logic {
    HEAP_OP_ENQUE     = 1'b0,
    HEAP_OP_DEQUE_MAX = 1'b1
  } heap_op_t;
endpackage

module bbq_deque_collector
  import bbq_pkg::*;
#(
  parameter int DWIDTH      = 32,
  parameter int PRIOR_WIDTH = 6,
  parameter int DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  input  logic                   issue_sel,
  output logic                   issue_ready,
  input  logic                   in_0_valid,
  input  heap_op_t               in_0_op_type,
  input  logic                   in_0_he_valid,
  input  logic [DWIDTH-1:0]      in_0_he_data,
  input  logic [PRIOR_WIDTH-1:0] in_0_he_priority,
  input  logic                   in_1_valid,
  input  heap_op_t               in_1_op_type,
  input  logic                   in_1_he_valid,
  input  logic [DWIDTH-1:0]      in_1_he_data,
  input  logic [PRIOR_WIDTH-1:0] in_1_he_priority,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_empty,
  output logic [DWIDTH-1:0]      out_data,
  output logic [PRIOR_WIDTH-1:0] out_priority,
  output logic [1:0]             err_flags
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef struct packed {
    logic                   he_valid;
    logic [DWIDTH-1:0]      data;
    logic [PRIOR_WIDTH-1:0] prio;
  } entry_t;

  logic          order_mem [DEPTH];
  logic [AW-1:0] order_wr, order_rd;
  logic [CW-1:0] order_cnt;

  entry_t        resp_mem [2][DEPTH];
  logic [AW-1:0] resp_wr [2];
  logic [AW-1:0] resp_rd [2];
  logic [CW-1:0] resp_cnt [2];
  logic [CW-1:0] outst [2];

  logic     rsp_valid [2];
  heap_op_t rsp_op [2];
  entry_t   rsp_entry [2];
  logic     issue_k [2];
  logic     cap [2];
  logic     unsol [2];
  logic     pop_k [2];
  logic     issue_acc, issue_heap, head_heap, pop;
  entry_t   head_entry;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    rsp_valid[0] = in_0_valid;
    rsp_valid[1] = in_1_valid;
    rsp_op[0]    = in_0_op_type;
    rsp_op[1]    = in_1_op_type;
    rsp_entry[0] = in_0_he_valid ? entry_t'{1'b1, in_0_he_data, in_0_he_priority} : '0;
    rsp_entry[1] = in_1_he_valid ? entry_t'{1'b1, in_1_he_data, in_1_he_priority} : '0;

    issue_ready = (order_cnt < CNT_FULL);
    issue_acc   = issue_valid && issue_ready;
    issue_heap  = !issue_sel;  // sel=1 addresses heap 0
    head_heap   = order_mem[order_rd];
    head_entry  = resp_mem[head_heap][resp_rd[head_heap]];
    out_valid   = (order_cnt != '0) && (resp_cnt[head_heap] != '0);
    pop         = out_valid && out_ready;

    for (int k = 0; k < 2; k++) begin
      issue_k[k] = issue_acc && (issue_heap == 1'(k));
      cap[k]     = rsp_valid[k] && (rsp_op[k] == HEAP_OP_DEQUE_MAX) && (outst[k] != '0);
      unsol[k]   = rsp_valid[k] && (rsp_op[k] == HEAP_OP_DEQUE_MAX) && (outst[k] == '0);
      pop_k[k]   = pop && (head_heap == 1'(k));
    end

    out_empty    = out_valid && !head_entry.he_valid;
    out_data     = out_valid ? head_entry.data : '0;
    out_priority = out_valid ? head_entry.prio : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      order_wr  <= '0;
      order_rd  <= '0;
      order_cnt <= '0;
      err_flags <= '0;
      for (int k = 0; k < 2; k++) begin
        resp_wr[k]  <= '0;
        resp_rd[k]  <= '0;
        resp_cnt[k] <= '0;
        outst[k]    <= '0;
      end
    end else begin
      if (issue_acc) order_wr <= order_wr + AW'(1);
      if (pop)       order_rd <= order_rd + AW'(1);
      case ({issue_acc, pop})
        2'b10:   order_cnt <= order_cnt + CW'(1);
        2'b01:   order_cnt <= order_cnt - CW'(1);
        default: order_cnt <= order_cnt;
      endcase

      for (int k = 0; k < 2; k++) begin
        if (cap[k])   resp_wr[k] <= resp_wr[k] + AW'(1);
        if (pop_k[k]) resp_rd[k] <= resp_rd[k] + AW'(1);
        case ({cap[k], pop_k[k]})
          2'b10:   resp_cnt[k] <= resp_cnt[k] + CW'(1);
          2'b01:   resp_cnt[k] <= resp_cnt[k] - CW'(1);
          default: resp_cnt[k] <= resp_cnt[k];
        endcase
        case ({issue_k[k], cap[k]})
          2'b10:   outst[k] <= outst[k] + CW'(1);
          2'b01:   outst[k] <= outst[k] - CW'(1);
          default: outst[k] <= outst[k];
        endcase
      end

      err_flags <= err_flags | {unsol[0] || unsol[1], issue_valid && !issue_ready};
    end
  end

  // NOTE: storage arrays carry no reset; validity is tracked entirely by the counters.
  always_ff @(posedge clk) begin
    if (issue_acc) order_mem[order_wr] <= issue_heap;
    for (int k = 0; k < 2; k++) begin
      if (cap[k]) resp_mem[k][resp_wr[k]] <= rsp_entry[k];
    end
  end

endmodule

// File: tb/tb_bbq_deque_collector.sv
// Self-checking bench for bbq_deque_collector: directed scenarios plus a random
// phase, all compared against a queue-based model of issue order and responses.
module tb_bbq_deque_collector;
  import bbq_pkg::*;

  localparam int DWIDTH      = 32;
  localparam int PRIOR_WIDTH = 6;
  localparam int DEPTH       = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   issue_valid, issue_sel, issue_ready;
  logic                   in_0_valid, in_0_he_valid;
  heap_op_t               in_0_op_type;
  logic [DWIDTH-1:0]      in_0_he_data;
  logic [PRIOR_WIDTH-1:0] in_0_he_priority;
  logic                   in_1_valid, in_1_he_valid;
  heap_op_t               in_1_op_type;
  logic [DWIDTH-1:0]      in_1_he_data;
  logic [PRIOR_WIDTH-1:0] in_1_he_priority;
  logic                   out_valid, out_ready, out_empty;
  logic [DWIDTH-1:0]      out_data;
  logic [PRIOR_WIDTH-1:0] out_priority;
  logic [1:0]             err_flags;

  bbq_deque_collector #(.DWIDTH(DWIDTH), .PRIOR_WIDTH(PRIOR_WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_sel(issue_sel), .issue_ready(issue_ready),
    .in_0_valid(in_0_valid), .in_0_op_type(in_0_op_type), .in_0_he_valid(in_0_he_valid),
    .in_0_he_data(in_0_he_data), .in_0_he_priority(in_0_he_priority),
    .in_1_valid(in_1_valid), .in_1_op_type(in_1_op_type), .in_1_he_valid(in_1_he_valid),
    .in_1_he_data(in_1_he_data), .in_1_he_priority(in_1_he_priority),
    .out_valid(out_valid), .out_ready(out_ready), .out_empty(out_empty),
    .out_data(out_data), .out_priority(out_priority), .err_flags(err_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                   hv;
    logic [DWIDTH-1:0]      d;
    logic [PRIOR_WIDTH-1:0] p;
  } ent_t;

  // Reference model: issue order, per-heap buffered results, outstanding counts.
  int       order_q[$];
  ent_t     q0[$];
  ent_t     q1[$];
  int       m_out[2];
  logic [1:0] m_err;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    order_q.delete();
    q0.delete();
    q1.delete();
    m_out[0] = 0;
    m_out[1] = 0;
    m_err    = 2'b00;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    issue_sel   = 1'b0;
    in_0_valid = 1'b0; in_0_op_type = HEAP_OP_ENQUE; in_0_he_valid = 1'b0;
    in_0_he_data = '0; in_0_he_priority = '0;
    in_1_valid = 1'b0; in_1_op_type = HEAP_OP_ENQUE; in_1_he_valid = 1'b0;
    in_1_he_data = '0; in_1_he_priority = '0;
  endtask

  task automatic set_rsp(input int k, input heap_op_t op, input logic hv,
                         input logic [DWIDTH-1:0] d, input logic [PRIOR_WIDTH-1:0] p);
    if (k == 0) begin
      in_0_valid = 1'b1; in_0_op_type = op; in_0_he_valid = hv;
      in_0_he_data = d; in_0_he_priority = p;
    end else begin
      in_1_valid = 1'b1; in_1_op_type = op; in_1_he_valid = hv;
      in_1_he_data = d; in_1_he_priority = p;
    end
  endtask

  task automatic issue(input logic sel);
    issue_valid = 1'b1;
    issue_sel   = sel;
  endtask

  // Called at a negedge with inputs already driven: compare, advance the model, step one cycle.
  task automatic tick();
    bit   ev, pop;
    int   h;
    ent_t he;
    ev = order_q.size() > 0 && (order_q[0] == 0 ? q0.size() > 0 : q1.size() > 0);
    check("issue_ready", issue_ready, order_q.size() < DEPTH);
    check("out_valid", out_valid, ev);
    check("err_flags", err_flags, m_err);
    if (ev) begin
      he = (order_q[0] == 0) ? q0[0] : q1[0];
      check("out_data", out_data, he.d);
      check("out_priority", out_priority, he.p);
      check("out_empty", out_empty, !he.hv);
    end
    pop = ev && out_ready;
    if (in_0_valid && in_0_op_type == HEAP_OP_DEQUE_MAX) begin
      if (m_out[0] > 0) begin
        q0.push_back(in_0_he_valid ? ent_t'{1'b1, in_0_he_data, in_0_he_priority}
                                   : ent_t'{1'b0, '0, '0});
        m_out[0]--;
      end else m_err[1] = 1'b1;
    end
    if (in_1_valid && in_1_op_type == HEAP_OP_DEQUE_MAX) begin
      if (m_out[1] > 0) begin
        q1.push_back(in_1_he_valid ? ent_t'{1'b1, in_1_he_data, in_1_he_priority}
                                   : ent_t'{1'b0, '0, '0});
        m_out[1]--;
      end else m_err[1] = 1'b1;
    end
    if (issue_valid) begin
      if (order_q.size() < DEPTH) begin
        h = issue_sel ? 0 : 1;
        order_q.push_back(h);
        m_out[h]++;
      end else m_err[0] = 1'b1;
    end
    if (pop) begin
      h = order_q.pop_front();
      if (h == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    out_ready = 1'b0;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    idle();
    out_ready = 1'b0;
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_issue_ready", issue_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("rst_out_empty", out_empty, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_priority", out_priority, '0);
    check("rst_err_flags", err_flags, 2'b00);
    rst = 1'b1;

    // Single issue to heap 0, response three cycles later.
    issue(1'b1); tick();
    idle(); tick(); tick();
    set_rsp(0, HEAP_OP_DEQUE_MAX, 1'b1, 32'hA5, 6'd7); tick();
    idle();
    check("t1_valid", out_valid, 1'b1);
    check("t1_data", out_data, 32'hA5);
    check("t1_prio", out_priority, 6'd7);
    check("t1_empty", out_empty, 1'b0);
    out_ready = 1'b1; tick();
    out_ready = 1'b0;
    check("t1_popped", out_valid, 1'b0);

    // Out-of-order completion is held back behind the earlier issue.
    issue(1'b1); tick();
    issue(1'b0); tick();
    idle(); set_rsp(1, HEAP_OP_DEQUE_MAX, 1'b1, 32'h22, 6'd2); tick();
    idle(); tick();
    check("t2_held", out_valid, 1'b0);
    set_rsp(0, HEAP_OP_DEQUE_MAX, 1'b1, 32'h11, 6'd1); tick();
    idle();
    check("t2_first", out_data, 32'h11);
    out_ready = 1'b1; tick();
    check("t2_second", out_data, 32'h22);
    tick();
    out_ready = 1'b0;

    // Fill the order FIFO, overflow once, then drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      issue(i[0] ? 1'b0 : 1'b1); tick();
    end
    idle();
    check("t3_full", issue_ready, 1'b0);
    issue(1'b1); tick();
    idle();
    check("t3_overflow", err_flags, 2'b01);
    set_rsp(0, HEAP_OP_DEQUE_MAX, 1'b1, 32'h30, 6'd30);
    set_rsp(1, HEAP_OP_DEQUE_MAX, 1'b1, 32'h31, 6'd31); tick();
    set_rsp(0, HEAP_OP_DEQUE_MAX, 1'b1, 32'h32, 6'd32);
    set_rsp(1, HEAP_OP_DEQUE_MAX, 1'b1, 32'h33, 6'd33); tick();
    idle();
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("t3_drain", out_data, 32'h30 + i);
      tick();
    end
    out_ready = 1'b0;
    check("t3_drained", out_valid, 1'b0);

    // Empty-heap response on heap 1.
    issue(1'b0); tick();
    idle(); set_rsp(1, HEAP_OP_DEQUE_MAX, 1'b0, 32'hDEAD, 6'd5); tick();
    idle();
    check("t4_empty", out_empty, 1'b1);
    check("t4_data", out_data, '0);
    check("t4_prio", out_priority, '0);
    out_ready = 1'b1; tick();
    out_ready = 1'b0;

    // Enqueue ack is silent; unsolicited dequeue response flags an error.
    do_reset();
    set_rsp(1, HEAP_OP_ENQUE, 1'b1, 32'h55, 6'd9); tick();
    idle();
    check("t5_enq_silent", err_flags, 2'b00);
    set_rsp(0, HEAP_OP_DEQUE_MAX, 1'b1, 32'h66, 6'd3); tick();
    idle();
    check("t5_unsol", err_flags, 2'b10);
    check("t5_no_out", out_valid, 1'b0);
    tick();

    // Asynchronous reset with two outstanding issues and one buffered result.
    issue(1'b1); tick();
    issue(1'b0); tick();
    issue(1'b1); tick();
    idle(); set_rsp(0, HEAP_OP_DEQUE_MAX, 1'b1, 32'h77, 6'd4); tick();
    idle();
    check("t6_pre_valid", out_valid, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("t6_valid", out_valid, 1'b0);
    check("t6_ready", issue_ready, 1'b1);
    check("t6_err", err_flags, 2'b00);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    set_rsp(1, HEAP_OP_DEQUE_MAX, 1'b1, 32'h88, 6'd8); tick();
    idle();
    check("t6_after_unsol", err_flags, 2'b10);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      int r;
      idle();
      if ($urandom_range(0, 2) != 0) issue(1'($urandom_range(0, 1)));
      out_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 2; k++) begin
        r = $urandom_range(0, 19);
        if ((m_out[k] > 0 && r < 8) || r == 19)
          set_rsp(k, HEAP_OP_DEQUE_MAX, ($urandom_range(0, 4) != 0), $urandom,
                  PRIOR_WIDTH'($urandom));
        else if (r == 18)
          set_rsp(k, HEAP_OP_ENQUE, 1'b1, $urandom, PRIOR_WIDTH'($urandom));
      end
      tick();
    end
    idle();
    out_ready = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
